// File: rtl/meta_rr_arbiter_if.sv
// ============================================================================
// Module   : meta_rr_arbiter_if
// Purpose  : Handshake bundle for meta_rr_arbiter (NUM_IN input streams
//            merged into one tagged output stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface meta_rr_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int DW     = 512,
    parameter int SW     = $clog2(NUM_IN)
);
    logic [NUM_IN*DW-1:0] in_data;
    logic [NUM_IN-1:0]    in_valid;
    logic [NUM_IN-1:0]    in_ready;
    logic [DW-1:0]        out_data;
    logic [SW-1:0]        out_src;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_almost_full;

    // Arbiter side
    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_src,
        output out_valid,
        input  out_ready,
        input  out_almost_full
    );

    // Producer / consumer side
    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_src,
        input  out_valid,
        output out_ready,
        output out_almost_full
    );
endinterface

`default_nettype wire

// File: rtl/meta_rr_arbiter.sv
// ============================================================================
// Module   : meta_rr_arbiter
// Purpose  : Per-flit round-robin merge of NUM_IN metadata streams into one
//            tagged stream through a 2-entry output buffer.
//            Optional macro META_ARB_STATS_EN adds per-input and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module meta_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DW     = 512,
    parameter int SW     = $clog2(NUM_IN)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    meta_rr_arbiter_if.master   bus,
    output logic [31:0]         stats_out_meta
`ifdef META_ARB_STATS_EN
    ,
    output logic [NUM_IN*32-1:0] stats_in_cnt,
    output logic [31:0]          stats_stall_cnt
`endif
);

    localparam logic [1:0] OCC_FULL = 2'd2;

    logic [SW-1:0] rr_ptr_q;
    logic [SW-1:0] rr_ptr_d;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic          out_valid_q;
    logic [DW-1:0] head_data_q;
    logic [SW-1:0] head_src_q;
    logic [DW-1:0] tail_data_q;
    logic [SW-1:0] tail_src_q;
    logic [31:0]   stats_out_meta_q;

    logic [SW-1:0] w_grant;
    logic          w_any_valid;
    logic          w_can_accept;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_grant_data;
    logic [SW:0]   w_idx;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_grant     = '0;
        w_any_valid = 1'b0;
        w_idx       = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (w_idx >= (SW+1)'(NUM_IN)) begin
                w_idx = w_idx - (SW+1)'(NUM_IN);
            end
            if (bus.in_valid[w_idx[SW-1:0]]) begin
                w_grant     = w_idx[SW-1:0];
                w_any_valid = 1'b1;
            end
        end
    end

    assign w_can_accept = !rst && (occ_q != OCC_FULL) && !bus.out_almost_full;
    assign w_push       = w_can_accept && w_any_valid;
    assign w_pop        = out_valid_q && bus.out_ready;
    assign w_grant_data = bus.in_data[w_grant*DW +: DW];

    always_comb begin
        bus.in_ready = '0;
        if (w_push) begin
            bus.in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_push) begin
            rr_ptr_d = (w_grant == SW'(NUM_IN - 1)) ? '0 : w_grant + SW'(1);
        end
    end

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Head register feeds the output directly; tail only holds the second flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q         <= '0;
            occ_q            <= '0;
            out_valid_q      <= 1'b0;
            head_data_q      <= '0;
            head_src_q       <= '0;
            tail_data_q      <= '0;
            tail_src_q       <= '0;
            stats_out_meta_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= (occ_d != 2'd0);

            if (w_pop && (occ_q == OCC_FULL)) begin
                head_data_q <= tail_data_q;
                head_src_q  <= tail_src_q;
            end else if (w_push && ((occ_q == 2'd0) || ((occ_q == 2'd1) && w_pop))) begin
                head_data_q <= w_grant_data;
                head_src_q  <= w_grant;
            end

            if (w_push && (occ_q == 2'd1) && !w_pop) begin
                tail_data_q <= w_grant_data;
                tail_src_q  <= w_grant;
            end

            if (w_pop) begin
                stats_out_meta_q <= stats_out_meta_q + 32'd1;
            end
        end
    end

    assign bus.out_data  = head_data_q;
    assign bus.out_src   = head_src_q;
    assign bus.out_valid = out_valid_q;
    assign stats_out_meta = stats_out_meta_q;

`ifdef META_ARB_STATS_EN
    logic [31:0] stall_cnt_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane_cnt
        logic [31:0] lane_cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                lane_cnt_q <= '0;
            end else if (w_push && (w_grant == SW'(i))) begin
                lane_cnt_q <= lane_cnt_q + 32'd1;
            end
        end

        assign stats_in_cnt[i*32 +: 32] = lane_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stats_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
